// File: rtl/win_pkg.sv
// Shared types and constants for the pix_win_gen sliding-window generator.
// Holds the FSM encoding, the RGB-to-gray weights and the packed RGB pixel type.
package win_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } state_t;

  localparam int unsigned GRAY_R = 77;
  localparam int unsigned GRAY_G = 150;
  localparam int unsigned GRAY_B = 29;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Weights sum to 256, so the 16-bit sum never overflows and >>8 is the gray level
  function automatic logic [7:0] rgb2gray(input rgb_t p);
    logic [15:0] acc;
    acc = 16'(GRAY_R * 32'(p.r) + GRAY_G * 32'(p.g) + GRAY_B * 32'(p.b));
    return acc[15:8];
  endfunction

endpackage

// File: rtl/pix_line_buf.sv
// Single-port line memory: registered write, combinational (read-first) read.
// One entry per image column holding the pixels of the previous lines.
module pix_line_buf #(
  parameter  int unsigned DEPTH = 64,
  parameter  int unsigned DW    = 16,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pix_win_gen.sv
// Streaming WIN x WIN sliding-window generator over a raster pixel stream.
// Optional RGB2GRAY_EN: 24-bit {R,G,B} input converted to 8-bit gray before buffering.
module pix_win_gen
  import win_pkg::*;
#(
  parameter  int unsigned IMG_W = 64,
  parameter  int unsigned IMG_H = 64,
  parameter  int unsigned WIN   = 3,
  parameter  int unsigned PW    = 8,
  localparam int unsigned XW    = $clog2(IMG_W),
  localparam int unsigned YW    = $clog2(IMG_H),
  localparam int unsigned WW    = WIN * WIN * PW
) (
  input  logic          clk,
  input  logic          resetn,
`ifdef RGB2GRAY_EN
  input  logic [23:0]   in_pix,
`else
  input  logic [PW-1:0] in_pix,
`endif
  input  logic          in_sof,
  input  logic          in_vld,
  output logic          in_rdy,
  output logic [WW-1:0] out_win,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_last,
  output logic          out_vld,
  input  logic          out_rdy
);

  localparam int unsigned LW = (WIN - 1) * PW;

  state_t        state, state_nxt;
  logic [XW-1:0] col, col_nxt, pos_x;
  logic [YW-1:0] row, row_nxt, pos_y;
  logic          acc, emit, last, buf_we;
  logic [PW-1:0] pix;
  logic [LW-1:0] rd_vec, wr_vec;
  logic [WW-1:0] win_q, win_nxt;

`ifdef RGB2GRAY_EN
  assign pix = rgb2gray(rgb_t'(in_pix));
`else
  assign pix = in_pix;
`endif

  assign in_rdy = !out_vld || out_rdy;
  assign acc    = in_vld && in_rdy;

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    pos_x     = col;
    pos_y     = row;
    emit      = 1'b0;
    last      = 1'b0;
    buf_we    = 1'b0;
    // A start-of-frame pixel always lands at (0,0), whatever the counters say
    if (in_sof) begin
      pos_x = '0;
      pos_y = '0;
    end
    if (acc && (in_sof || state != IDLE)) begin
      buf_we = 1'b1;
      if (pos_x == XW'(IMG_W - 1)) begin
        col_nxt = '0;
        row_nxt = pos_y + YW'(1);
      end else begin
        col_nxt = pos_x + XW'(1);
        row_nxt = pos_y;
      end
      if (in_sof || state == FILL) begin
        state_nxt = (pos_x == XW'(IMG_W - 1) && pos_y == YW'(WIN - 2)) ? STREAM : FILL;
      end else begin
        emit = (pos_x >= XW'(WIN - 1));
        if (pos_x == XW'(IMG_W - 1) && pos_y == YW'(IMG_H - 1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
          col_nxt   = '0;
          row_nxt   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
    end
  end

  // Line entry r: r=0 oldest line; write shifts lines toward 0 and appends the new pixel
  always_comb begin
    wr_vec = '0;
    for (int unsigned r = 0; r < WIN - 2; r++) begin
      wr_vec[r*PW +: PW] = rd_vec[(r+1)*PW +: PW];
    end
    wr_vec[(WIN-2)*PW +: PW] = pix;
  end

  pix_line_buf #(
    .DEPTH (IMG_W),
    .DW    (LW)
  ) u_line_buf (
    .clk   (clk),
    .we    (buf_we),
    .addr  (pos_x),
    .wdata (wr_vec),
    .rdata (rd_vec)
  );

  always_comb begin
    win_nxt = win_q;
    for (int unsigned r = 0; r < WIN; r++) begin
      for (int unsigned c = 0; c < WIN - 1; c++) begin
        win_nxt[(r*WIN+c)*PW +: PW] = win_q[(r*WIN+c+1)*PW +: PW];
      end
    end
    for (int unsigned r = 0; r < WIN - 1; r++) begin
      win_nxt[(r*WIN+WIN-1)*PW +: PW] = rd_vec[r*PW +: PW];
    end
    win_nxt[((WIN-1)*WIN+WIN-1)*PW +: PW] = pix;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      win_q    <= '0;
      out_win  <= '0;
      out_x    <= '0;
      out_y    <= '0;
      out_last <= 1'b0;
      out_vld  <= 1'b0;
    end else begin
      if (acc) win_q <= win_nxt;
      if (acc && emit) begin
        out_vld  <= 1'b1;
        out_win  <= win_nxt;
        out_x    <= pos_x - XW'(WIN - 1);
        out_y    <= pos_y - YW'(WIN - 1);
        out_last <= last;
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pix_win_gen.sv
// Directed self-checking bench for pix_win_gen (8x6 frame, WIN=3, pixel = off + y*16 + x).
// With RGB2GRAY_EN defined it instead checks gray conversion on a 2x2 frame with WIN=2.
module tb_pix_win_gen;

`ifdef RGB2GRAY_EN
  localparam int IMG_W = 2;
  localparam int IMG_H = 2;
  localparam int WIN   = 2;
  localparam int IW    = 24;
`else
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int WIN   = 3;
  localparam int IW    = 8;
`endif
  localparam int PW   = 8;
  localparam int WW   = WIN * WIN * PW;
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int NX   = IMG_W - WIN + 1;
  localparam int NWIN = NX * (IMG_H - WIN + 1);
  localparam int NPIX = IMG_W * IMG_H;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [IW-1:0] in_pix = '0;
  logic          in_sof = 1'b0;
  logic          in_vld = 1'b0;
  logic          in_rdy;
  logic [WW-1:0] out_win;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          out_last;
  logic          out_vld;
  logic          out_rdy = 1'b1;

  int errors = 0;
  int checks = 0;

  logic [WW-1:0] cap_win  [0:511];
  logic [XW-1:0] cap_x    [0:511];
  logic [YW-1:0] cap_y    [0:511];
  logic          cap_last [0:511];
  int            cap_n = 0;

  pix_win_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .WIN   (WIN),
    .PW    (PW)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_pix   (in_pix),
    .in_sof   (in_sof),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .out_win  (out_win),
    .out_x    (out_x),
    .out_y    (out_y),
    .out_last (out_last),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so values seen here hold through the next edge
  always @(negedge clk) begin
    if (resetn && out_vld && out_rdy && cap_n < 512) begin
      cap_win[cap_n]  = out_win;
      cap_x[cap_n]    = out_x;
      cap_y[cap_n]    = out_y;
      cap_last[cap_n] = out_last;
      cap_n++;
    end
  end

  function automatic logic [WW-1:0] exp_win(input int x, input int y, input int off);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        w[(r*WIN+c)*PW +: PW] = 8'(off + (y + r) * 16 + (x + c));
    return w;
  endfunction

  function automatic logic [IW-1:0] pv(input int off, input int idx);
    return IW'(off + (idx / IMG_W) * 16 + (idx % IMG_W));
  endfunction

  task automatic send_pix(input logic [IW-1:0] p, input logic sof);
    bit ok;
    ok     = 1'b0;
    in_pix = p;
    in_sof = sof;
    in_vld = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = in_rdy;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_pix_timeout pixel=%h got in_rdy=0 want in_rdy=1 within 100 cycles", p);
    end
    in_sof = 1'b0;
  endtask

  task automatic send_range(input int off, input int first, input int stop, input bit sof_first);
    for (int i = first; i < stop; i++) send_pix(pv(off, i), sof_first && (i == first));
  endtask

  task automatic drain();
    in_vld = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    in_vld = 1'b0;
    out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
    checks++; if (out_win !== '0) begin errors++; $display("FAIL reset_out_win got %h want 0", out_win); end
    checks++; if ({out_x, out_y} !== '0) begin errors++; $display("FAIL reset_xy got x=%0d y=%0d want 0/0", out_x, out_y); end
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

`ifdef RGB2GRAY_EN
  task automatic test_rgb2gray();
    logic [7:0] want [4];
    int base;
    want[0] = 8'd255; want[1] = 8'd38; want[2] = 8'd149; want[3] = 8'd0;
    base = cap_n;
    send_pix(24'hFFFFFF, 1'b1);
    send_pix(24'h800000, 1'b0);
    send_pix(24'h00FF00, 1'b0);
    send_pix(24'h000000, 1'b0);
    checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL rgb_out_vld got %b want 1", out_vld); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL rgb_out_last got %b want 1", out_last); end
    checks++; if ({out_x, out_y} !== '0) begin errors++; $display("FAIL rgb_xy got x=%0d y=%0d want 0/0", out_x, out_y); end
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (out_win[e*PW +: PW] !== want[e]) begin
        errors++;
        $display("FAIL rgb_gray%0d got %0d want %0d", e, out_win[e*PW +: PW], want[e]);
      end
    end
    drain();
    checks++; if (cap_n - base !== 1) begin errors++; $display("FAIL rgb_count got %0d want 1", cap_n - base); end
  endtask
`else
  task automatic test_full_frame();
    int base;
    base = cap_n;
    send_range(0, 0, 18, 1'b1);
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL first_early_vld got %b want 0", out_vld); end
    send_pix(pv(0, 18), 1'b0);
    checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL first_vld got %b want 1", out_vld); end
    checks++;
    if ({out_x, out_y} !== {XW'(0), YW'(0)} || out_win[(WIN+1)*PW +: PW] !== 8'h11) begin
      errors++;
      $display("FAIL first_win got x=%0d y=%0d center=%h want 0/0/11", out_x, out_y, out_win[(WIN+1)*PW +: PW]);
    end
    send_range(0, 19, NPIX, 1'b0);
    drain();
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL full_idle_vld got %b want 0", out_vld); end
    checks++; if (cap_n - base !== NWIN) begin errors++; $display("FAIL full_count got %0d want %0d", cap_n - base, NWIN); end
    checks++;
    if (cap_x[base+23] !== XW'(5) || cap_y[base+23] !== YW'(3) || cap_last[base+23] !== 1'b1 ||
        cap_win[base+23][(WIN+1)*PW +: PW] !== 8'h46) begin
      errors++;
      $display("FAIL full_last got x=%0d y=%0d last=%b center=%h want 5/3/1/46", cap_x[base+23], cap_y[base+23],
               cap_last[base+23], cap_win[base+23][(WIN+1)*PW +: PW]);
    end
    for (int k = 0; k < NWIN; k++) begin
      checks++;
      if ({cap_win[base+k], cap_x[base+k], cap_y[base+k], cap_last[base+k]} !==
          {exp_win(k % NX, k / NX, 0), XW'(k % NX), YW'(k / NX), k == NWIN - 1}) begin
        errors++;
        $display("FAIL full_win%0d got %h x=%0d y=%0d last=%b want %h", k, cap_win[base+k], cap_x[base+k],
                 cap_y[base+k], cap_last[base+k], exp_win(k % NX, k / NX, 0));
      end
    end
  endtask

  task automatic test_stall();
    int base;
    base = cap_n;
    send_range(0, 0, 30, 1'b1);
    out_rdy = 1'b0;
    in_pix  = pv(0, 30);
    in_sof  = 1'b0;
    in_vld  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL stall_in_rdy got %b want 0", in_rdy); end
      checks++;
      if ({out_vld, out_win, out_x, out_y} !== {1'b1, exp_win(3, 1, 0), XW'(3), YW'(1)}) begin
        errors++;
        $display("FAIL stall_hold got vld=%b win=%h x=%0d y=%0d want 1 %h 3/1", out_vld, out_win, out_x, out_y,
                 exp_win(3, 1, 0));
      end
    end
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    send_range(0, 30, NPIX, 1'b0);
    drain();
    checks++; if (cap_n - base !== NWIN) begin errors++; $display("FAIL stall_count got %0d want %0d", cap_n - base, NWIN); end
    for (int k = 0; k < NWIN; k++) begin
      checks++;
      if ({cap_win[base+k], cap_x[base+k], cap_y[base+k], cap_last[base+k]} !==
          {exp_win(k % NX, k / NX, 0), XW'(k % NX), YW'(k / NX), k == NWIN - 1}) begin
        errors++;
        $display("FAIL stall_win%0d got %h x=%0d y=%0d want %h", k, cap_win[base+k], cap_x[base+k], cap_y[base+k],
                 exp_win(k % NX, k / NX, 0));
      end
    end
  endtask

  task automatic test_idle_drop();
    int base;
    base = cap_n;
    for (int i = 0; i < 10; i++) send_pix(IW'(8'hA0 + i), 1'b0);
    drain();
    checks++; if (cap_n !== base || out_vld !== 1'b0) begin errors++; $display("FAIL idle_drop got %0d windows vld=%b want 0/0", cap_n - base, out_vld); end
    send_range(5, 0, NPIX, 1'b1);
    drain();
    checks++; if (cap_n - base !== NWIN) begin errors++; $display("FAIL idle_count got %0d want %0d", cap_n - base, NWIN); end
    for (int k = 0; k < NWIN; k++) begin
      checks++;
      if ({cap_win[base+k], cap_x[base+k], cap_y[base+k]} !== {exp_win(k % NX, k / NX, 5), XW'(k % NX), YW'(k / NX)}) begin
        errors++;
        $display("FAIL idle_win%0d got %h x=%0d y=%0d want %h", k, cap_win[base+k], cap_x[base+k], cap_y[base+k],
                 exp_win(k % NX, k / NX, 5));
      end
    end
  endtask

  task automatic test_sof_restart();
    int base;
    base = cap_n;
    send_range(0, 0, 28, 1'b1);
    send_range(8'h80, 0, NPIX, 1'b1);
    drain();
    checks++; if (cap_n - base !== 8 + NWIN) begin errors++; $display("FAIL restart_count got %0d want %0d", cap_n - base, 8 + NWIN); end
    checks++; if (cap_win[base+8] !== exp_win(0, 0, 8'h80)) begin errors++; $display("FAIL restart_first got %h want %h", cap_win[base+8], exp_win(0, 0, 8'h80)); end
    for (int k = 0; k < 8 + NWIN; k++) begin
      int j, off;
      j   = (k < 8) ? k : k - 8;
      off = (k < 8) ? 0 : 8'h80;
      checks++;
      if ({cap_win[base+k], cap_x[base+k], cap_y[base+k]} !== {exp_win(j % NX, j / NX, off), XW'(j % NX), YW'(j / NX)}) begin
        errors++;
        $display("FAIL restart_win%0d got %h x=%0d y=%0d want %h", k, cap_win[base+k], cap_x[base+k], cap_y[base+k],
                 exp_win(j % NX, j / NX, off));
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    send_range(0, 0, 20, 1'b1);
    in_vld = 1'b0;
    resetn = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
        errors++;
        $display("FAIL midreset got vld=%b rdy=%b want 0/1", out_vld, in_rdy);
      end
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    base = cap_n;
    send_range(8'h30, 0, NPIX, 1'b1);
    drain();
    checks++; if (cap_n - base !== NWIN) begin errors++; $display("FAIL midreset_count got %0d want %0d", cap_n - base, NWIN); end
    for (int k = 0; k < NWIN; k++) begin
      checks++;
      if ({cap_win[base+k], cap_x[base+k], cap_y[base+k], cap_last[base+k]} !==
          {exp_win(k % NX, k / NX, 8'h30), XW'(k % NX), YW'(k / NX), k == NWIN - 1}) begin
        errors++;
        $display("FAIL midreset_win%0d got %h x=%0d y=%0d want %h", k, cap_win[base+k], cap_x[base+k], cap_y[base+k],
                 exp_win(k % NX, k / NX, 8'h30));
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
`ifdef RGB2GRAY_EN
    test_rgb2gray();
`else
    test_full_frame();
    test_stall();
    test_idle_drop();
    test_sof_restart();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
